// File: rtl/issuer_pkg.sv
// Shared types and default sizing for the single-issue operand issuer.
// The FSM encoding lives here so the issuer and any tooling agree on state values.
package issuer_pkg;

   localparam int DEF_WIDTH    = 32;
   localparam int DEF_NREGS    = 8;
   localparam int DEF_EXEC_LAT = 1;

   // Wide enough for EXEC_LAT-1 with EXEC_LAT up to 7.
   localparam int CNT_W = 3;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      WB   = 2'd2
   } state_t;

   function automatic logic [CNT_W-1:0] lat_preload(input int lat);
      return CNT_W'(lat - 1);
   endfunction

endpackage

// File: rtl/operand_regfile.sv
// Register file with two capture-on-enable read ports, a combinational debug
// port and one write port. Entry i resets to i; entry 0 is constant zero.
module operand_regfile #(
   parameter int WIDTH = 32,
   parameter int NREGS = 8,
   parameter int AW    = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             rd_en_i,
   input  logic [AW-1:0]    ra1_i,
   input  logic [AW-1:0]    ra2_i,
   output logic [WIDTH-1:0] rd1_o,
   output logic [WIDTH-1:0] rd2_o,
   input  logic [AW-1:0]    dbg_addr_i,
   output logic [WIDTH-1:0] dbg_data_o,
   input  logic             we_i,
   input  logic [AW-1:0]    wa_i,
   input  logic [WIDTH-1:0] wd_i
);

   logic [WIDTH-1:0] rf_rd [NREGS];
   logic [WIDTH-1:0] rd1_q;
   logic [WIDTH-1:0] rd2_q;

   genvar gi;
   generate
      for (gi = 0; gi < NREGS; gi++) begin : g_entry
         if (gi == 0) begin : g_zero
            assign rf_rd[gi] = '0;
         end else begin : g_reg
            logic [WIDTH-1:0] entry_q;
            always_ff @(posedge clk) begin
               if (reset) begin
                  entry_q <= WIDTH'(gi);
               end else if (we_i && (wa_i == AW'(gi))) begin
                  entry_q <= wd_i;
               end
            end
            assign rf_rd[gi] = entry_q;
         end
      end
   endgenerate

   // Operands are captured only on an accept and held until the next one.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd1_q <= '0;
         rd2_q <= '0;
      end else if (rd_en_i) begin
         rd1_q <= rf_rd[ra1_i];
         rd2_q <= rf_rd[ra2_i];
      end
   end

   assign rd1_o      = rd1_q;
   assign rd2_o      = rd2_q;
   assign dbg_data_o = rf_rd[dbg_addr_i];

endmodule

// File: rtl/operand_issuer.sv
// Single-issue front end: reads two operands, waits EXEC_LAT clocks for the
// external executor, then writes its result back. One instruction in flight.
module operand_issuer
   import issuer_pkg::*;
#(
   parameter int WIDTH    = DEF_WIDTH,
   parameter int NREGS    = DEF_NREGS,
   parameter int EXEC_LAT = DEF_EXEC_LAT,
   parameter int AW       = $clog2(NREGS)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [AW-1:0]    in_dst,
   input  logic [AW-1:0]    in_src1,
   input  logic [AW-1:0]    in_src2,
   output logic [WIDTH-1:0] op1_o,
   output logic [WIDTH-1:0] op2_o,
   input  logic [WIDTH-1:0] result_i,
   output logic             wb_valid,
   output logic [AW-1:0]    wb_dst,
   output logic [WIDTH-1:0] wb_data,
   input  logic [AW-1:0]    dbg_addr,
   output logic [WIDTH-1:0] dbg_data
);

   localparam logic [CNT_W-1:0] LAT_M1 = lat_preload(EXEC_LAT);

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [AW-1:0]    dst_q, dst_d;
   logic             accept;
   logic             rf_we;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = EXEC;
         EXEC:    if (cnt_q == '0) state_d = WB;
         WB:      state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // in_ready is gated by reset so nothing is accepted while reset is held.
   always_comb begin
      in_ready = 1'b0;
      wb_valid = 1'b0;
      wb_dst   = '0;
      wb_data  = '0;
      rf_we    = 1'b0;
      if (state_q == IDLE && !reset) begin
         in_ready = 1'b1;
      end
      if (state_q == WB) begin
         wb_valid = 1'b1;
         wb_dst   = dst_q;
         wb_data  = result_i;
         rf_we    = !reset;
      end
   end

   assign accept = in_valid && in_ready;

   always_comb begin
      cnt_d = cnt_q;
      dst_d = dst_q;
      if (accept) begin
         cnt_d = LAT_M1;
         dst_d = in_dst;
      end else if (state_q == EXEC && cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
         dst_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         dst_q <= dst_d;
      end
   end

   operand_regfile #(
      .WIDTH (WIDTH),
      .NREGS (NREGS),
      .AW    (AW)
   ) u_rf (
      .clk        (clk),
      .reset      (reset),
      .rd_en_i    (accept),
      .ra1_i      (in_src1),
      .ra2_i      (in_src2),
      .rd1_o      (op1_o),
      .rd2_o      (op2_o),
      .dbg_addr_i (dbg_addr),
      .dbg_data_o (dbg_data),
      .we_i       (rf_we),
      .wa_i       (wb_dst),
      .wd_i       (wb_data)
   );

endmodule

// File: tb/tb_operand_issuer.sv
// Directed bench: a 32-bit issuer with a combinational adder and an 8-bit
// issuer with a 3-stage adder, both checked against hand-computed values.
module tb_operand_issuer;

   logic clk;
   logic reset;

   logic        a_valid, a_ready, a_wbv;
   logic [2:0]  a_dst, a_s1, a_s2, a_wbd, a_dbga;
   logic [31:0] a_op1, a_op2, a_res, a_wbdata, a_dbgd;

   logic        b_valid, b_ready, b_wbv;
   logic [2:0]  b_dst, b_s1, b_s2, b_wbd, b_dbga;
   logic [7:0]  b_op1, b_op2, b_res, b_wbdata, b_dbgd, b_p0, b_p1;

   int n_checks = 0;
   int n_fail   = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Executors: A is a plain adder, B delays its sum by two extra edges.
   assign a_res = a_op1 + a_op2;
   always @(posedge clk) begin
      b_p0 <= b_op1 + b_op2;
      b_p1 <= b_p0;
   end
   assign b_res = b_p1;

   operand_issuer #(.WIDTH(32), .NREGS(8), .EXEC_LAT(1)) dut_a (
      .clk(clk), .reset(reset), .in_valid(a_valid), .in_ready(a_ready),
      .in_dst(a_dst), .in_src1(a_s1), .in_src2(a_s2),
      .op1_o(a_op1), .op2_o(a_op2), .result_i(a_res),
      .wb_valid(a_wbv), .wb_dst(a_wbd), .wb_data(a_wbdata),
      .dbg_addr(a_dbga), .dbg_data(a_dbgd)
   );

   operand_issuer #(.WIDTH(8), .NREGS(8), .EXEC_LAT(3)) dut_b (
      .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_ready),
      .in_dst(b_dst), .in_src1(b_s1), .in_src2(b_s2),
      .op1_o(b_op1), .op2_o(b_op2), .result_i(b_res),
      .wb_valid(b_wbv), .wb_dst(b_wbd), .wb_data(b_wbdata),
      .dbg_addr(b_dbga), .dbg_data(b_dbgd)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_ready_a(input string tag);
      int n = 0;
      while (!a_ready && n < 20) begin
         tick();
         n++;
      end
      if (!a_ready) check({tag, " ready timeout"}, 32'(a_ready), 32'd1);
   endtask

   task automatic read_a(input logic [2:0] idx, input logic [31:0] exp, input string tag);
      a_dbga = idx;
      #1;
      check(tag, a_dbgd, exp);
   endtask

   task automatic read_b(input logic [2:0] idx, input logic [7:0] exp, input string tag);
      b_dbga = idx;
      #1;
      check(tag, 32'(b_dbgd), 32'(exp));
   endtask

   // EXEC_LAT=1: accept at edge k, WB after edge k+1, idle again after k+2.
   task automatic issue_a(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                          input logic [31:0] e1, input logic [31:0] e2, input logic [31:0] ewb,
                          input string tag);
      wait_ready_a(tag);
      a_valid = 1'b1; a_dst = d; a_s1 = s1; a_s2 = s2;
      tick();
      a_valid = 1'b0; a_dst = $urandom_range(7); a_s1 = $urandom_range(7); a_s2 = $urandom_range(7);
      check({tag, " op1"}, a_op1, e1);
      check({tag, " op2"}, a_op2, e2);
      check({tag, " busy ready"}, 32'(a_ready), 32'd0);
      check({tag, " exec wb_valid"}, 32'(a_wbv), 32'd0);
      tick();
      check({tag, " wb_valid"}, 32'(a_wbv), 32'd1);
      check({tag, " wb_dst"}, 32'(a_wbd), 32'(d));
      check({tag, " wb_data"}, a_wbdata, ewb);
      tick();
      check({tag, " post wb_valid"}, 32'(a_wbv), 32'd0);
      check({tag, " post ready"}, 32'(a_ready), 32'd1);
   endtask

   // EXEC_LAT=3: count edges from accept to the WB pulse.
   task automatic issue_b(input logic [2:0] d, input logic [2:0] s1, input logic [2:0] s2,
                          input logic [7:0] ewb, input string tag);
      int n = 0;
      while (!b_ready && n < 20) begin
         tick();
         n++;
      end
      b_valid = 1'b1; b_dst = d; b_s1 = s1; b_s2 = s2;
      tick();
      b_valid = 1'b0;
      n = 0;
      while (!b_wbv && n < 20) begin
         tick();
         n++;
      end
      check({tag, " latency"}, 32'(n), 32'd3);
      check({tag, " wb_dst"}, 32'(b_wbd), 32'(d));
      check({tag, " wb_data"}, 32'(b_wbdata), 32'(ewb));
      tick();
   endtask

   initial begin
      int acc_cycles;
      int pulses;
      logic seen;
      logic [7:0] vals [6];

      a_valid = 0; a_dst = 0; a_s1 = 0; a_s2 = 0; a_dbga = 0;
      b_valid = 0; b_dst = 0; b_s1 = 0; b_s2 = 0; b_dbga = 0;
      reset = 1'b1;
      repeat (3) tick();
      check("reset in_ready", 32'(a_ready), 32'd0);
      check("reset op1", a_op1, 32'd0);
      check("reset op2", a_op2, 32'd0);
      check("reset wb_valid", 32'(a_wbv), 32'd0);
      check("reset wb_dst", 32'(a_wbd), 32'd0);
      check("reset wb_data", a_wbdata, 32'd0);
      reset = 1'b0;
      #1;
      check("ready after reset", 32'(a_ready), 32'd1);
      for (int i = 0; i < 8; i++) read_a(3'(i), 32'(i), $sformatf("reset rf_a[%0d]", i));
      for (int i = 0; i < 8; i++) read_b(3'(i), 8'(i), $sformatf("reset rf_b[%0d]", i));

      issue_a(3'd3, 3'd1, 3'd2, 32'd1, 32'd2, 32'd3, "r3=r1+r2");
      read_a(3'd3, 32'd3, "rf[3]");
      issue_a(3'd4, 3'd3, 3'd3, 32'd3, 32'd3, 32'd6, "r4=r3+r3");
      read_a(3'd4, 32'd6, "rf[4]");
      issue_a(3'd0, 3'd1, 3'd2, 32'd1, 32'd2, 32'd3, "r0=r1+r2");
      read_a(3'd0, 32'd0, "rf[0] stays 0");

      // Abort an instruction in EXEC with reset.
      wait_ready_a("abort");
      a_valid = 1'b1; a_dst = 3'd5; a_s1 = 3'd1; a_s2 = 3'd1;
      tick();
      a_valid = 1'b0;
      reset = 1'b1;
      pulses = 0;
      tick();
      if (a_wbv) pulses++;
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (a_wbv) pulses++;
      end
      check("abort wb pulses", 32'(pulses), 32'd0);
      read_a(3'd5, 32'd5, "abort rf[5]");
      read_a(3'd3, 32'd3, "abort rf[3] restored");
      read_a(3'd4, 32'd4, "abort rf[4] restored");

      // Hold a second instruction valid while the first is in flight.
      wait_ready_a("held");
      a_valid = 1'b1; a_dst = 3'd1; a_s1 = 3'd1; a_s2 = 3'd1;
      tick();
      a_dst = 3'd6; a_s1 = 3'd2; a_s2 = 3'd3;
      acc_cycles = 0;
      seen = 1'b0;
      while (!seen && acc_cycles < 20) begin
         seen = a_ready;
         tick();
         if (!seen) acc_cycles++;
      end
      a_valid = 1'b0;
      check("held busy cycles", 32'(acc_cycles), 32'd2);
      check("held op1", a_op1, 32'd2);
      check("held op2", a_op2, 32'd3);
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         if (a_wbv) begin
            pulses++;
            check("held wb_data", a_wbdata, 32'd5);
         end
         tick();
      end
      check("held wb pulses", 32'(pulses), 32'd1);
      read_a(3'd6, 32'd5, "held rf[6]");
      read_a(3'd1, 32'd2, "held rf[1]");

      // 8-bit wrap: 7 doubled six times.
      vals[0] = 8'd14; vals[1] = 8'd28; vals[2] = 8'd56;
      vals[3] = 8'd112; vals[4] = 8'd224; vals[5] = 8'hC0;
      for (int i = 0; i < 6; i++) issue_b(3'd7, 3'd7, 3'd7, vals[i], $sformatf("b r7+=r7 #%0d", i));
      read_b(3'd7, 8'hC0, "b rf[7] wrap");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
